// File: rtl/paddle_buttons.sv
// Debounces two paddle buttons and emits a one-cycle press pulse plus a level bit per channel.
// Optional per-channel press holdoff is enabled by defining PADDLE_HOLDOFF_EN.
module paddle_buttons #(
    parameter int unsigned HOLDOFF_CYCLES = 64
) (
    input  logic        _i_clk,
    input  logic        _i_rst,
    input  logic [1:0]  _i_btn,
    input  logic [31:0] _i_debounce_len,
    output logic [3:0]  __output
);

    if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
        $error("HOLDOFF_CYCLES must be at least 1");
    end

    logic [1:0]  sync1_q, sync2_q;
    logic [1:0]  stable_q, stable_d;
    logic [1:0]  pulse_q, pulse_d;
    logic [1:0]  rise;
    logic [31:0] cnt_q [2];
    logic [31:0] cnt_d [2];
    logic [31:0] len_eff;

    // A window of 0 would never let cnt+1 fall below it, so treat it as 1.
    assign len_eff = (_i_debounce_len == 32'd0) ? 32'd1 : _i_debounce_len;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            stable_d[c] = stable_q[c];
            cnt_d[c]    = '0;
            if (sync2_q[c] != stable_q[c]) begin
                if (({1'b0, cnt_q[c]} + 33'd1) >= {1'b0, len_eff}) begin
                    stable_d[c] = sync2_q[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + 32'd1;
                end
            end
            rise[c] = stable_d[c] & ~stable_q[c];
        end
    end

`ifdef PADDLE_HOLDOFF_EN
    logic [31:0] holdoff_q [2];
    logic [31:0] holdoff_d [2];

    // A counter at 1 reaches 0 on this edge, so a press qualifying now still fires.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            pulse_d[c]   = rise[c] && (holdoff_q[c] <= 32'd1);
            holdoff_d[c] = (holdoff_q[c] != 32'd0) ? holdoff_q[c] - 32'd1 : 32'd0;
            if (pulse_d[c]) begin
                holdoff_d[c] = 32'(HOLDOFF_CYCLES);
            end
        end
    end

    always_ff @(posedge _i_clk or negedge _i_rst) begin
        if (!_i_rst) begin
            for (int c = 0; c < 2; c++) begin
                holdoff_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                holdoff_q[c] <= holdoff_d[c];
            end
        end
    end
`else
    always_comb begin
        pulse_d = rise;
    end
`endif

    always_ff @(posedge _i_clk or negedge _i_rst) begin
        if (!_i_rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            pulse_q  <= '0;
            for (int c = 0; c < 2; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            sync1_q  <= _i_btn;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            for (int c = 0; c < 2; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign __output = {stable_q, pulse_q};

endmodule

// File: tb/tb_paddle_buttons.sv
// Directed bench for paddle_buttons: latency, bounce rejection, L=0/1, dual press, reset, holdoff.
module tb_paddle_buttons;

    logic        clk;
    logic        rst;
    logic [1:0]  btn;
    logic [31:0] len;
    logic [3:0]  out;

    int checks = 0;
    int errors = 0;
    int pulses;

    paddle_buttons #(.HOLDOFF_CYCLES(8)) dut (
        ._i_clk          (clk),
        ._i_rst          (rst),
        ._i_btn          (btn),
        ._i_debounce_len (len),
        .__output        (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [3:0] exp);
        checks++;
        assert (out === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, out, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        btn = 2'b00;
        len = 32'd3;
        ticks(2);
        check("reset_out", 4'b0000);
        rst = 1'b1;
        ticks(3);
        check("idle_out", 4'b0000);

        // L=3, left press: level and pulse rise at N+4
        btn = 2'b01;
        tick();                 // edge N
        ticks(3);               // N+3
        check("l3_before", 4'b0000);
        tick();                 // N+4
        check("l3_pulse", 4'b0101);
        tick();
        check("l3_pulse_end", 4'b0100);
        ticks(5);
        check("l3_held_one_pulse", 4'b0100);
        btn = 2'b00;
        tick();                 // release edge R
        ticks(3);
        check("l3_release_before", 4'b0100);
        tick();
        check("l3_release_fall", 4'b0000);

        // L=4 bounce 1,0,1,0 then hold
        len = 32'd4;
        ticks(2);
        btn = 2'b01; tick();
        btn = 2'b00; tick();
        btn = 2'b01; tick();
        btn = 2'b00; tick();
        check("bounce_quiet", 4'b0000);
        btn = 2'b01;
        tick();                 // N
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out[0]) pulses++;
        end
        check_int("bounce_no_early_pulse", pulses, 0);
        tick();                 // N+5
        check("bounce_pulse", 4'b0101);
        btn = 2'b00;
        ticks(8);
        check("bounce_released", 4'b0000);

        // L=0 behaves as L=1
        len = 32'd0;
        btn = 2'b01;
        tick();
        tick();
        check("l0_before", 4'b0000);
        tick();
        check("l0_pulse", 4'b0101);
        btn = 2'b00;
        ticks(4);
        len = 32'd1;
        btn = 2'b01;
        tick();
        tick();
        check("l1_before", 4'b0000);
        tick();
        check("l1_pulse", 4'b0101);
        btn = 2'b00;
        ticks(4);
        check("l1_released", 4'b0000);

        // Lowering L mid-count commits on that edge
        len = 32'd10;
        btn = 2'b01;
        tick();                 // N
        ticks(3);               // cnt=2
        check("lower_before", 4'b0000);
        len = 32'd2;
        tick();
        check("lower_commit", 4'b0101);
        btn = 2'b00;
        ticks(5);

        // Both buttons with L=2
        len = 32'd2;
        btn = 2'b11;
        tick();
        ticks(2);
        check("dual_before", 4'b0000);
        tick();
        check("dual_pulse", 4'b1111);
        tick();
        check("dual_level", 4'b1100);
        btn = 2'b00;
        tick();                 // R
        ticks(2);
        check("dual_rel_before", 4'b1100);
        tick();
        check("dual_rel_fall", 4'b0000);
        tick();
        check("dual_rel_no_pulse", 4'b0000);

        // Reset mid-window, L=5; right already held
        len = 32'd5;
        btn = 2'b10;
        tick();
        ticks(6);
        check("right_pulse_l5", 4'b1010);
        tick();
        check("right_level_l5", 4'b1000);
        btn = 2'b11;
        tick();                 // N for left
        ticks(3);               // left cnt=2
        check("midwin_before_rst", 4'b1000);
        #2 rst = 1'b0;
        #1;
        check("async_reset_clear", 4'b0000);
        ticks(2);
        check("reset_held", 4'b0000);
        rst = 1'b1;
        tick();                 // first post-reset sampling edge
        ticks(5);
        check("post_rst_before", 4'b0000);
        tick();
        check("post_rst_pulse", 4'b1111);
        tick();
        check("post_rst_level", 4'b1100);
        btn = 2'b00;
        ticks(8);

        // Press/release/press within 6 cycles, L=1
        len = 32'd1;
        pulses = 0;
        btn = 2'b01; tick(); if (out[0]) pulses++;
        tick(); if (out[0]) pulses++;
        btn = 2'b00; tick(); if (out[0]) pulses++;
        tick(); if (out[0]) pulses++;
        btn = 2'b01;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out[0]) pulses++;
        end
`ifdef PADDLE_HOLDOFF_EN
        check_int("rapid_press_pulses", pulses, 1);
`else
        check_int("rapid_press_pulses", pulses, 2);
`endif
        btn = 2'b00;
        ticks(12);
        pulses = 0;
        btn = 2'b01;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out[0]) pulses++;
        end
        check_int("late_press_pulses", pulses, 1);
        check("late_press_level", 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/paddle_buttons.md
PADDLE_BUTTONS -- requirements
Module: paddle_buttons

Interface
REQ-001 Parameter HOLDOFF_CYCLES, default 64, is the number of cycles after a press pulse during which further presses on that channel are ignored (used only with PADDLE_HOLDOFF_EN).
REQ-002 _i_clk  input  1  is the single clock; all state is on its rising edge.
REQ-003 _i_rst  input  1  is the reset: asynchronous, active-low.
REQ-004 _i_btn  input  2  carries the raw asynchronous paddle buttons: bit0 = left player, bit1 = right player; high = pressed.
REQ-005 _i_debounce_len  input  32  is the debounce window L in cycles; a value of 0 SHALL be treated as 1.
REQ-006 __output  output  4  is packed as follows, and feeds the pong hit inputs:
- bit0 = left press pulse.
- bit1 = right press pulse.
- bit2 = left debounced level.
- bit3 = right debounced level.

Function
REQ-007 The two channels SHALL be identical and fully independent; no channel state SHALL depend on the other channel.
REQ-008 Each channel SHALL pass _i_btn through a 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-009 Each channel SHALL hold a debounced state `stable` and a 32-bit counter `cnt`.
REQ-010 Debounce update, evaluated each cycle:
- If sync2 equals stable, cnt SHALL clear to 0.
- Otherwise, if cnt+1 >= L, stable SHALL take sync2 and cnt SHALL clear to 0.
- Otherwise cnt SHALL increment by 1.
REQ-011 The cnt comparison SHALL use the current _i_debounce_len every cycle. Lowering L mid-count so that cnt+1 >= L SHALL commit stable on that same edge.
REQ-012 cnt SHALL never exceed L-1 and SHALL never wrap.
REQ-013 Any glitch on sync2 back to the stable value SHALL restart the window from 0.
REQ-014 Latency: the raw input is first sampled high at edge N and then held. The level bit and the press pulse SHALL both rise at edge N+1+L.
REQ-015 The level bit SHALL equal stable and be driven from a register.
REQ-016 The press pulse SHALL be a registered, one-cycle pulse asserted on the edge where stable goes 0->1.
REQ-017 Release (stable going 1->0) SHALL update only the level bit; it SHALL never produce a pulse.
REQ-018 A held button SHALL produce exactly one pulse until it is released and pressed again.
REQ-019 Simultaneous qualifying presses on both channels in the same cycle SHALL assert both pulse bits in the same cycle.

Reset
REQ-020 While _i_rst is low, all of the following SHALL clear to 0 asynchronously: sync1, sync2, stable, cnt, holdoff counters and __output.
REQ-021 Deassertion of _i_rst SHALL take effect on the next rising _i_clk edge.
REQ-022 Reset asserted mid-window SHALL discard the partial count.
REQ-023 A button held through reset SHALL be treated as a new press after reset: one pulse at edge N+1+L, counted from the first post-reset sampling edge N.

Configuration
REQ-024 Macro PADDLE_HOLDOFF_EN, when defined, SHALL enable a per-channel holdoff counter, as follows:
- The counter loads HOLDOFF_CYCLES on each emitted pulse and decrements to 0.
- While the counter is nonzero, 0->1 transitions of stable SHALL update the level bit but SHALL NOT emit a pulse.
- A pulse qualifying on the exact edge where the counter reaches 0 SHALL be emitted.
REQ-025 Without PADDLE_HOLDOFF_EN, no holdoff logic SHALL exist, and every 0->1 transition of stable SHALL emit a pulse.

Verification
REQ-026 Scenario: L=3, hold _i_btn=01 from edge 20 -> bit2 and bit0 rise at edge 24; bit0 low at edge 25; bit2 stays high.
REQ-027 Scenario: L=4, left input bounces 1,0,1,0 on alternating cycles, then holds 1 from edge 40 -> no pulse before edge 45; exactly one pulse at edge 45.
REQ-028 Scenario: L=0 and L=1 -> identical behaviour; a press sampled at edge 10 pulses at edge 12.
REQ-029 Scenario: both buttons rise on the same edge with L=2 -> bits 0 and 1 pulse together at edge N+3; release produces no pulse and the level bits fall at the release edge+3.
REQ-030 Scenario: reset driven low mid-window (cnt=2 of L=5) -> __output=0 immediately without waiting for a clock edge; after reset release the held button pulses at first sampling edge+6.
REQ-031 Scenario: with PADDLE_HOLDOFF_EN and HOLDOFF_CYCLES=8, L=1, press/release/press within 6 cycles -> one pulse only; press again after 8 cycles -> second pulse. Without the macro, the same stimulus -> two pulses.
